truth_table_capture: RTL

//  Sequential sweep-and-capture engine for small combinational gate blocks (4-input SOP class).
//  On start it drives every input vector 0..2**N_IN-1 onto vec_out and samples the DUT response f_in.
//  It assembles the sampled responses into a truth-table word and compares that word against EXPECTED.

---
 rtl/truth_table_capture.sv | 134 +++++++++++++
 1 files changed

// File: rtl/truth_table_capture.sv
// Sweep-and-capture engine: drives every input vector to a small gate block,
// records its response into a truth table and compares it against a golden word.
module truth_table_capture #(
   parameter int unsigned                N_IN     = 4,
   parameter int unsigned                SETTLE   = 1,
   parameter logic [(1 << N_IN) - 1 : 0] EXPECTED = 16'h2F22
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          f_in,
   output logic [N_IN-1:0]               vec_out,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic [(1 << N_IN) - 1 : 0]    table_out,
   output logic [N_IN-1:0]               fail_idx
);

   localparam int unsigned TW = 1 << N_IN;
   localparam int unsigned CW = $clog2(SETTLE + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_SAMPLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN-1:0] fidx_q, fidx_d;
   logic [N_IN-1:0] first_diff;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tbl_q, tbl_d;
   logic [TW-1:0]   diff;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   state_t          vec_entry;

   // With no settle cycles each vector lives only in SAMPLE
   assign vec_entry = (SETTLE == 0) ? S_SAMPLE : S_HOLD;

   // Lowest mismatching table index; zero when the table matches
   always_comb begin
      diff       = tbl_q ^ EXPECTED;
      first_diff = '0;
      for (int i = TW - 1; i >= 0; i--) begin
         if (diff[i]) first_diff = N_IN'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      fidx_d  = fidx_q;
      cnt_d   = cnt_q;
      tbl_d   = tbl_q;
      busy_d  = busy_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = vec_entry;
               vec_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               tbl_d   = '0;
               pass_d  = 1'b0;
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(SETTLE)) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            tbl_d[vec_q] = f_in;
            if (vec_q == N_IN'(TW - 1)) begin
               state_d = S_CHECK;
               busy_d  = 1'b0;
            end else begin
               vec_d   = vec_q + N_IN'(1);
               cnt_d   = '0;
               state_d = vec_entry;
            end
         end
         S_CHECK: begin
            pass_d  = (tbl_q == EXPECTED);
            fidx_d  = first_diff;
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         fidx_q  <= '0;
         cnt_q   <= '0;
         tbl_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         fidx_q  <= fidx_d;
         cnt_q   <= cnt_d;
         tbl_q   <= tbl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign vec_out   = vec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign table_out = tbl_q;
   assign fail_idx  = fidx_q;

endmodule
